rtl_reqack_arb: RTL and testbench

- Round-robin consumer for NCH upstream REQ/ACK FIFO channels, each presenting req/reqinfo/ack/vld.
- Selects one requesting channel and pulses its ack. Captures that channel's reqinfo when its vld arrives.
- Presents the captured word, tagged with its channel number, on a single valid/ready output toward the downstream engine.
- Watchdog catches an upstream that never returns vld.

---
 rtl/rtl_reqack_pkg.sv | 22 ++
 rtl/rtl_rrpick.sv | 38 +++
 rtl/rtl_reqack_arb.sv | 163 ++++++++++++++++
 tb/tb_rtl_reqack_arb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtl_reqack_pkg.sv
// rtl_reqack_pkg: shared FSM encoding and helpers for the REQ/ACK arbiter.
// Imported by rtl_rrpick and rtl_reqack_arb.
package rtl_reqack_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACK  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    // Number of bits needed to index n entries (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rtl_rrpick.sv
// rtl_rrpick: combinational round-robin picker.
// Returns the first requester found scanning upward from rrptr, wrapping.
module rtl_rrpick
    import rtl_reqack_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] rrptr,
    output logic [CHW-1:0] gnt,
    output logic           anyreq
);

    localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

    // Scan farthest-first so the closest requester to rrptr wins last.
    always_comb begin
        logic [CHW:0]   sum;
        logic [CHW-1:0] idx;
        gnt    = '0;
        anyreq = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            sum = {1'b0, rrptr} + (CHW+1)'(k);
            if (sum >= NCH_W) begin
                sum = sum - NCH_W;
            end
            idx = sum[CHW-1:0];
            if (req[idx]) begin
                gnt    = idx;
                anyreq = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtl_reqack_arb.sv
// rtl_reqack_arb: round-robin consumer of NCH REQ/ACK FIFO channels.
// Build option RTL_REQACK_ARB_PRIO0_EN gives channel 0 strict priority.
module rtl_reqack_arb
    import rtl_reqack_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CHW   = clog2(NCH),
    parameter int WIDTH = 128,
    parameter int TMO   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] reqinfo,
    output logic [NCH-1:0]       ack,
    input  logic [NCH-1:0]       vld,
    input  logic                 enable,
    output logic                 outvld,
    output logic [WIDTH-1:0]     outdat,
    output logic [CHW-1:0]       outch,
    input  logic                 outrdy,
    output logic                 busy,
    output logic                 tmoerr
);

    localparam logic [7:0]     TMO_M1 = 8'(TMO - 1);
    localparam logic [CHW-1:0] LAST   = CHW'(NCH - 1);

    state_t           state;
    state_t           state_d;
    logic [CHW-1:0]   rrptr;
    logic [CHW-1:0]   gnt;
    logic [CHW-1:0]   pick;
    logic [CHW-1:0]   sel;
    logic [CHW-1:0]   nxt;
    logic [NCH-1:0]   sel_oh;
    logic [7:0]       wdcnt;
    logic             anyreq;
    logic             vld_g;
    logic             wd_last;
    logic             keep;
    logic             take;
    logic             capture;
    logic             abort;
    logic             done;
    logic [WIDTH-1:0] info [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_info
        assign info[i] = reqinfo[i*WIDTH +: WIDTH];
    end

    rtl_rrpick #(
        .NCH    (NCH),
        .CHW    (CHW)
    ) u_pick (
        .req    (req),
        .rrptr  (rrptr),
        .gnt    (pick),
        .anyreq (anyreq)
    );

`ifdef RTL_REQACK_ARB_PRIO0_EN
    // Channel 0 bypasses the rotation and never moves the pointer.
    assign sel  = req[0] ? '0 : pick;
    assign keep = (gnt == '0);
`else
    assign sel  = pick;
    assign keep = 1'b0;
`endif

    assign sel_oh  = NCH'(1) << sel;
    assign vld_g   = vld[gnt];
    assign wd_last = (wdcnt >= TMO_M1);
    assign nxt     = (gnt == LAST) ? '0 : gnt + CHW'(1);
    assign busy    = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode from the per-state events.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (take) state_d = ST_ACK;
            ST_ACK:  state_d = capture ? ST_OUT : ST_WAIT;
            ST_WAIT: begin
                if (capture) begin
                    state_d = ST_OUT;
                end else if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT:  if (done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state events that drive the registered datapath.
    always_comb begin
        take    = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        done    = 1'b0;
        unique case (state)
            ST_IDLE: take = enable & anyreq;
            ST_ACK:  capture = vld_g;
            ST_WAIT: begin
                capture = vld_g;
                abort   = ~vld_g & wd_last;
            end
            ST_OUT:  done = outrdy;
            default: ;
        endcase
    end

    // Registered grant, ack pulse, capture, watchdog and pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt    <= '0;
            rrptr  <= '0;
            ack    <= '0;
            outvld <= 1'b0;
            outdat <= '0;
            outch  <= '0;
            tmoerr <= 1'b0;
            wdcnt  <= '0;
        end else begin
            ack    <= '0;
            tmoerr <= 1'b0;
            if (take) begin
                gnt <= sel;
                ack <= sel_oh;
            end
            if (capture) begin
                outdat <= info[gnt];
                outch  <= gnt;
                outvld <= 1'b1;
            end else if (done) begin
                outvld <= 1'b0;
            end
            if (state == ST_ACK) begin
                wdcnt <= 8'd1;
            end else if (state == ST_WAIT) begin
                wdcnt <= wdcnt + 8'd1;
            end else begin
                wdcnt <= '0;
            end
            if (abort) begin
                tmoerr <= 1'b1;
            end
            if ((done || abort) && !keep) begin
                rrptr <= nxt;
            end
        end
    end

endmodule

// File: tb/tb_rtl_reqack_arb.sv
// tb_rtl_reqack_arb: scoreboard bench for the REQ/ACK arbiter.
// Grants and captured words are queued on stimulus and popped on output.
module tb_rtl_reqack_arb;

    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int WIDTH = 128;
    localparam int TMO   = 15;

    typedef struct packed {
        logic [CHW-1:0]   ch;
        logic [WIDTH-1:0] dat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] reqinfo;
    logic [NCH-1:0]       ack;
    logic [NCH-1:0]       vld = '0;
    logic                 enable;
    logic                 outvld;
    logic [WIDTH-1:0]     outdat;
    logic [CHW-1:0]       outch;
    logic                 outrdy;
    logic                 busy;
    logic                 tmoerr;

    exp_t           sb[$];
    int             gq[$];
    int             nchk = 0;
    int             nerr = 0;
    int             ack_seen = 0;
    int             ack_target = 0;
    int             tmo_seen = 0;
    int             cyc = 0;
    int             last_ack = 0;
    int             lat [NCH];
    logic [NCH-1:0] prev_ack = '0;
    int             pend_ch = 0;
    int             pend_cnt = 0;
    bit             pend = 1'b0;

    always #5 clk = ~clk;

    rtl_reqack_arb #(
        .NCH     (NCH),
        .CHW     (CHW),
        .WIDTH   (WIDTH),
        .TMO     (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .reqinfo (reqinfo),
        .ack     (ack),
        .vld     (vld),
        .enable  (enable),
        .outvld  (outvld),
        .outdat  (outdat),
        .outch   (outch),
        .outrdy  (outrdy),
        .busy    (busy),
        .tmoerr  (tmoerr)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] info_of(input int ch);
        return 128'hA0 + 128'(ch);
    endfunction

    function automatic int idx_of(input logic [NCH-1:0] a);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (a[i]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Upstream model: answer each ack after lat[ch] cycles (255 = never).
    always @(posedge clk) begin
        #1;
        vld = '0;
        if (ack != '0) begin
            pend_ch = idx_of(ack);
            pend    = (lat[pend_ch] < 255);
            pend_cnt = lat[pend_ch];
        end else if (pend) begin
            pend_cnt--;
        end
        if (pend && pend_cnt == 0) begin
            vld[pend_ch] = 1'b1;
            sb.push_back('{ch: CHW'(pend_ch), dat: info_of(pend_ch)});
            pend = 1'b0;
        end
    end

    // Monitor: grant order, single ack pulses, output words, watchdog.
    always @(negedge clk) begin
        if (ack != '0) begin
            ack_seen++;
            last_ack = cyc;
            check("ack_onehot", 128'($onehot(ack)), 1);
            check("ack_pulse", prev_ack, 0);
            if (gq.size() == 0) begin
                check("ack_unexp", ack, 0);
            end else begin
                check("grant", ack, 128'(1) << gq.pop_front());
            end
        end
        prev_ack = ack;
        if (outvld && outrdy) begin
            if (sb.size() == 0) begin
                check("out_unexp", outvld, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("outch", outch, e.ch);
                check("outdat", outdat, e.dat);
            end
        end
        if (tmoerr) begin
            tmo_seen++;
            check("tmo_lat", cyc - last_ack, TMO);
        end
    end

    task automatic wait_acks(input int n);
        int t;
        ack_target += n;
        t = 0;
        while (ack_seen < ack_target && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("acks", ack_seen, ack_target);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || gq.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size() + gq.size(), 0);
        check("idle", busy, 0);
    endtask

    task automatic wait_outvld();
        int t;
        t = 0;
        while (!outvld && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("outvld_rise", outvld, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        foreach (lat[i]) lat[i] = 0;
        for (int i = 0; i < NCH; i++) begin
            reqinfo[i*WIDTH +: WIDTH] = info_of(i);
        end
        rst    = 1'b0;
        req    = 4'b1111;
        enable = 1'b1;
        outrdy = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("rst_ack", ack, 0);
            check("rst_outvld", outvld, 0);
            check("rst_busy", busy, 0);
            check("rst_tmoerr", tmoerr, 0);
        end
        check("rst_outdat", outdat, 0);
        check("rst_outch", outch, 0);

        // Round robin over all four channels with wrap.
`ifdef RTL_REQACK_ARB_PRIO0_EN
        for (int i = 0; i < 5; i++) gq.push_back(0);
`else
        gq.push_back(0);
        gq.push_back(1);
        gq.push_back(2);
        gq.push_back(3);
        gq.push_back(0);
`endif
        tick();
        rst = 1'b1;
        wait_acks(5);
        tick();
        req = '0;
        drain();

        // Late vld on ch1 plus output backpressure.
        gq.push_back(1);
        lat[1] = 5;
        outrdy = 1'b0;
        req = 4'b0010;
        wait_acks(1);
        tick();
        req = '0;
        wait_outvld();
        for (int i = 0; i < 4; i++) begin
            check("hold_vld", outvld, 1);
            check("hold_ch", outch, 1);
            check("hold_dat", outdat, info_of(1));
            if (i < 3) @(negedge clk);
        end
        tick();
        outrdy = 1'b1;
        drain();
        lat[1] = 0;

        // ch2 never answers: watchdog abort, then ch3 is next.
        gq.push_back(2);
        gq.push_back(3);
        lat[2] = 255;
        req = 4'b1100;
        wait_acks(2);
        tick();
        req = '0;
        drain();
        check("tmo_count", tmo_seen, 1);
        lat[2] = 0;

        // enable drops while waiting: finish the job, grant nothing more.
        gq.push_back(0);
        lat[0] = 6;
        req = 4'b0001;
        wait_acks(1);
        tick();
        tick();
        enable = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("no_grant", ack_seen, ack_target);
        req = '0;
        lat[0] = 0;

        // Reset while holding an output word.
        enable = 1'b1;
        outrdy = 1'b0;
        gq.push_back(2);
        req = 4'b0100;
        wait_acks(1);
        tick();
        req = '0;
        wait_outvld();
        tick();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("flush_outvld", outvld, 0);
        check("flush_busy", busy, 0);
        check("flush_outdat", outdat, 0);
        sb.delete();
        tick();
        rst = 1'b1;
        outrdy = 1'b1;
        gq.push_back(0);
        req = 4'b1111;
        wait_acks(1);
        tick();
        req = '0;
        drain();

`ifdef RTL_REQACK_ARB_PRIO0_EN
        // Channel 0 dominates; the rest rotate once it goes quiet.
        for (int i = 0; i < 3; i++) gq.push_back(0);
        req = 4'b1011;
        wait_acks(3);
        gq.push_back(1);
        gq.push_back(3);
        gq.push_back(1);
        gq.push_back(3);
        tick();
        req = 4'b1010;
        wait_acks(4);
        tick();
        req = '0;
        drain();
`endif

        check("tmo_total", tmo_seen, 1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
